// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Control FSM for a five-state multicycle MIPS-subset datapath.
// The state sequence is IF -> ID -> EX -> MEM -> WB.
// Every output other than the state register is combinational in
// (state, op, funct). Exception: equal also feeds PCWrite in EX for branches.
//
// Optional feature: define MULTICYCLE_CTRL_BNE_EN to support bne (op 000101).
// bne then behaves like beq, except that PCWrite follows ~equal.
// Without the macro, op 000101 is flagged illegal in ID.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset; outputs are forced to 0 while it is high
//   op        IR[31:26]
//   funct     IR[5:0]
//   equal     register A == register B
//   PCWrite, IRWrite, RegWrite, MemWrite   write strobes
//   ALUSrcA, ALUSrcB, ALUOp                ALU operand and operation selects
//   RegDst, MemToReg, PCSource             datapath selects
//   state     current state, for debug
//   illegal   unsupported opcode seen in ID
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       equal,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [5:0] ALUOp,
  output logic       RegDst,
  output logic       MemToReg,
  output logic [1:0] PCSource,
  output logic [2:0] state,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] ALU_ADDU = 6'b100001;
  localparam logic [5:0] ALU_SUBU = 6'b100011;

  state_t cur_state;
  state_t next_state;

  logic       is_rtype;
  logic       is_itype;
  logic       is_lw;
  logic       is_sw;
  logic       is_beq;
  logic       is_bne;
  logic       is_j;
  logic       is_branch;
  logic       supported;
  logic       shift_imm;
  logic [5:0] itype_aluop;

  assign is_rtype = (op == OP_RTYPE);
  // All I-type ALU ops share the prefix 001xxx.
  assign is_itype = (op[5:3] == 3'b001);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_j     = (op == OP_J);
`ifdef MULTICYCLE_CTRL_BNE_EN
  assign is_bne   = (op == 6'b000101);
`else
  assign is_bne   = 1'b0;
`endif
  assign is_branch = is_beq | is_bne;
  assign supported = is_rtype | is_itype | is_lw | is_sw | is_branch | is_j;

  // Shifts by the constant shamt take operand A from the instruction field.
  assign shift_imm = (funct == 6'b000000) || (funct == 6'b000010) ||
                     (funct == 6'b000011);

  // ALU function for the I-type ALU instructions.
  always_comb begin
    itype_aluop = 6'b000000;
    case (op[2:0])
      3'b000: itype_aluop = 6'b100000;
      3'b001: itype_aluop = 6'b100001;
      3'b010: itype_aluop = 6'b101010;
      3'b011: itype_aluop = 6'b101011;
      3'b100: itype_aluop = 6'b110100;
      3'b101: itype_aluop = 6'b110101;
      3'b110: itype_aluop = 6'b110110;
      3'b111: itype_aluop = 6'b110000;
      default: itype_aluop = 6'b000000;
    endcase
  end

  // State register. Reset returns to IF immediately, which aborts any
  // instruction that is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= S_IF;
    else       cur_state <= next_state;
  end

  assign state = cur_state;

  // Next-state and output decode. Every output defaults to 0.
  // While reset is high, all outputs are held at 0, so IF's strobes
  // cannot fire during reset.
  always_comb begin
    next_state = S_IF;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 6'b000000;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    PCSource   = 2'b00;
    illegal    = 1'b0;
    if (!reset) begin
      case (cur_state)
        S_IF: begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          ALUSrcB    = 2'b01;
          ALUOp      = ALU_ADDU;
          next_state = S_ID;
        end
        S_ID: begin
          // The branch target is computed speculatively for every instruction.
          ALUSrcB = 2'b11;
          ALUOp   = ALU_ADDU;
          if (is_j) begin
            PCWrite    = 1'b1;
            PCSource   = 2'b10;
            next_state = S_IF;
          end else if (!supported) begin
            illegal    = 1'b1;
            next_state = S_IF;
          end else begin
            next_state = S_EX;
          end
        end
        S_EX: begin
          if (is_rtype) begin
            ALUSrcA    = shift_imm ? 2'b10 : 2'b01;
            ALUOp      = funct;
            next_state = S_WB;
          end else if (is_itype) begin
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            ALUOp      = itype_aluop;
            next_state = S_WB;
          end else if (is_lw || is_sw) begin
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            ALUOp      = ALU_ADDU;
            next_state = S_MEM;
          end else if (is_branch) begin
            ALUSrcA  = 2'b01;
            ALUOp    = ALU_SUBU;
            PCSource = 2'b01;
            PCWrite  = is_bne ? ~equal : equal;
          end
        end
        S_MEM: begin
          if (is_sw) MemWrite = 1'b1;
          else if (is_lw) next_state = S_WB;
        end
        S_WB: begin
          RegWrite = 1'b1;
          RegDst   = is_rtype;
          MemToReg = is_lw;
        end
        default: next_state = S_IF;
      endcase
    end
  end

endmodule
